// File: rtl/tk1_led_pwm.sv
// Three-channel PWM generator for the RGB LED driver with an optional
// blink sequencer gating all channels over whole PWM periods.
//
// Blink FSM states:
//   state  | meaning
//   ST_ON  | PWM outputs follow the shadow duties
//   ST_OFF | all PWM outputs held low for the current blink phase
module tk1_led_pwm #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [2:0]  led_pwm
);

    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_DUTY0     = 8'h01;
    localparam logic [7:0] ADDR_DUTY1     = 8'h02;
    localparam logic [7:0] ADDR_DUTY2     = 8'h03;
    localparam logic [7:0] ADDR_BLINK_ON  = 8'h04;
    localparam logic [7:0] ADDR_BLINK_OFF = 8'h05;
    localparam logic [7:0] ADDR_STATUS    = 8'h06;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_OFF = 1'b1
    } blink_state_e;

    logic [1:0]       ctrl_q, ctrl_d;
    logic [2:0][7:0]  duty_q, duty_d;
    logic [15:0]      blink_on_q, blink_on_d;
    logic [15:0]      blink_off_q, blink_off_d;
    logic [15:0]      presc_q, presc_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [2:0][7:0]  shadow_q, shadow_d;
    blink_state_e     state_q, state_d;
    logic [15:0]      blink_cnt_q, blink_cnt_d;
    logic [2:0]       led_pwm_q, led_pwm_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             ready_q, ready_d;

    logic             enable;
    logic             blink_en;
    logic             tick;
    logic             boundary;
    logic             phase_on;
    logic [15:0]      limit;
    logic [16:0]      blink_cnt_inc;
    logic             unused_wdata_hi;

    assign enable          = ctrl_q[0];
    assign blink_en        = ctrl_q[1];
    assign tick            = enable && (presc_q == PRESC_MAX);
    assign boundary        = tick && (pwm_cnt_q == 8'hFF);
    assign phase_on        = (state_q == ST_ON);
    assign unused_wdata_hi = ^write_data[31:16];

    // Register file writes on cs & we; unmapped and STATUS writes fall through.
    always_comb begin
        ctrl_d      = ctrl_q;
        duty_d      = duty_q;
        blink_on_d  = blink_on_q;
        blink_off_d = blink_off_q;
        if (cs && we) begin
            case (address)
                ADDR_CTRL:      ctrl_d      = write_data[1:0];
                ADDR_DUTY0:     duty_d[0]   = write_data[7:0];
                ADDR_DUTY1:     duty_d[1]   = write_data[7:0];
                ADDR_DUTY2:     duty_d[2]   = write_data[7:0];
                ADDR_BLINK_ON:  blink_on_d  = write_data[15:0];
                ADDR_BLINK_OFF: blink_off_d = write_data[15:0];
                default: ;
            endcase
        end
    end

    // Read mux and ready pulse; read_data is zero outside the ready cycle.
    always_comb begin
        read_data_d = '0;
        ready_d     = cs;
        if (cs && !we) begin
            case (address)
                ADDR_CTRL:      read_data_d = {30'h0, ctrl_q};
                ADDR_DUTY0:     read_data_d = {24'h0, duty_q[0]};
                ADDR_DUTY1:     read_data_d = {24'h0, duty_q[1]};
                ADDR_DUTY2:     read_data_d = {24'h0, duty_q[2]};
                ADDR_BLINK_ON:  read_data_d = {16'h0, blink_on_q};
                ADDR_BLINK_OFF: read_data_d = {16'h0, blink_off_q};
                ADDR_STATUS:    read_data_d = {16'h0, pwm_cnt_q, 7'h0, phase_on};
                default:        read_data_d = '0;
            endcase
        end
    end

    // Prescaler and PWM counter, held at zero while disabled; shadows track
    // DUTY while disabled so an enable starts with the current values.
    always_comb begin
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        shadow_d  = shadow_q;
        if (!enable) begin
            presc_d   = '0;
            pwm_cnt_d = '0;
        end else if (tick) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            presc_d   = presc_q + 16'd1;
        end
        if (!enable || boundary) begin
            shadow_d = duty_q;
        end
    end

    // Blink FSM: advances once per PWM period; a zero limit counts as one.
    always_comb begin
        state_d       = state_q;
        blink_cnt_d   = blink_cnt_q;
        limit         = (state_q == ST_ON) ? blink_on_q : blink_off_q;
        if (limit == 16'd0) begin
            limit = 16'd1;
        end
        blink_cnt_inc = {1'b0, blink_cnt_q} + 17'd1;
        if (!blink_en) begin
            state_d     = ST_ON;
            blink_cnt_d = '0;
        end else if (boundary) begin
            if (blink_cnt_inc >= {1'b0, limit}) begin
                state_d     = (state_q == ST_ON) ? ST_OFF : ST_ON;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_inc[15:0];
            end
        end
    end

    // PWM compare, registered one cycle behind counter/shadow/phase.
    always_comb begin
        led_pwm_d = '0;
        for (int i = 0; i < 3; i++) begin
            led_pwm_d[i] = enable && phase_on && (pwm_cnt_q < shadow_q[i]);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            duty_q      <= '0;
            blink_on_q  <= '0;
            blink_off_q <= '0;
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            shadow_q    <= '0;
            state_q     <= ST_ON;
            blink_cnt_q <= '0;
            led_pwm_q   <= '0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            duty_q      <= duty_d;
            blink_on_q  <= blink_on_d;
            blink_off_q <= blink_off_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            shadow_q    <= shadow_d;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            led_pwm_q   <= led_pwm_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign led_pwm   = led_pwm_q;

endmodule

// File: tb/tb_tk1_led_pwm.sv
// Bench for tk1_led_pwm: two instances (PRESCALE 1 and 4) share one bus.
module tb_tk1_led_pwm;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] rd_p1, rd_p4;
    logic        rdy_p1, rdy_p4;
    logic [2:0]  led_p1, led_p4;

    int total = 0;
    int bad   = 0;

    tk1_led_pwm #(.PRESCALE(1)) u_p1 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd_p1), .ready(rdy_p1), .led_pwm(led_p1)
    );

    tk1_led_pwm #(.PRESCALE(4)) u_p4 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(rd_p4), .ready(rdy_p4), .led_pwm(led_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        @(posedge clk); #1;
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        int hi0_p1[6];
        int hi4[3];
        int hb[4][3];
        int mis_p1, mis_p4, mis_b;
        int ph, ph4, d0, p;
        logic [2:0] exp1, exp4, expb;
        logic on;

        cs = 1'b0; we = 1'b0; address = '0; write_data = '0;
        reset_n = 1'b0;
        #2;
        check("reset_led_p1", 32'(led_p1), 32'h0);
        check("reset_led_p4", 32'(led_p4), 32'h0);
        check("reset_ready", 32'(rdy_p1), 32'h0);
        check("reset_rdata", rd_p1, 32'h0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;

        // Phase 1: steady PWM, then mid-period DUTY0 write at pwm_cnt 10.
        bus_write(8'h01, 32'h40);
        bus_write(8'h02, 32'hFF);
        bus_write(8'h03, 32'h03);
        bus_write(8'h00, 32'h1);
        mis_p1 = 0; mis_p4 = 0;
        foreach (hi0_p1[i]) hi0_p1[i] = 0;
        foreach (hi4[i]) hi4[i] = 0;
        for (int k = 1; k <= 1536; k++) begin
            @(posedge clk); #1;
            if (k == 1) check("first_high_after_enable", 32'(led_p1[0]), 32'h1);
            ph = (k - 1) % 256;
            d0 = (k <= 1280) ? 64 : 192;
            exp1 = {ph < 3, ph < 255, ph < d0};
            if (led_p1 !== exp1) mis_p1++;
            if (led_p1[0]) hi0_p1[(k - 1) / 256]++;
            if (k <= 1024) begin
                ph4 = ((k - 1) / 4) % 256;
                exp4 = {ph4 < 3, ph4 < 255, ph4 < 64};
                if (led_p4 !== exp4) mis_p4++;
                for (int c = 0; c < 3; c++) if (led_p4[c]) hi4[c]++;
            end
            if (k == 1034) begin
                cs = 1'b1; we = 1'b1; address = 8'h01; write_data = 32'hC0;
            end
            if (k == 1035) begin
                cs = 1'b0; we = 1'b0;
            end
        end
        check("p1_pattern_mismatches", 32'(mis_p1), 32'h0);
        check("p1_ch0_high_period0", 32'(hi0_p1[0]), 32'd64);
        check("p1_ch0_high_write_period", 32'(hi0_p1[4]), 32'd64);
        check("p1_ch0_high_next_period", 32'(hi0_p1[5]), 32'd192);
        check("p4_pattern_mismatches", 32'(mis_p4), 32'h0);
        check("p4_ch0_high", 32'(hi4[0]), 32'd256);
        check("p4_ch1_high", 32'(hi4[1]), 32'd1020);
        check("p4_ch2_high", 32'(hi4[2]), 32'd12);

        // Asynchronous reset while an output is high.
        @(posedge clk); #1;
        check("pre_reset_high", 32'(led_p1[0]), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_led_p1", 32'(led_p1), 32'h0);
        check("async_reset_led_p4", 32'(led_p4), 32'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Register table after reset.
        vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 8'h01, 32'h0, 32'h0};
        vecs[2]  = '{1'b0, 8'h02, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 8'h03, 32'h0, 32'h0};
        vecs[4]  = '{1'b0, 8'h04, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, 8'h05, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 8'h06, 32'h0, 32'h1};
        vecs[7]  = '{1'b1, 8'h00, 32'hFFFF_FFFC, 32'h0};
        vecs[8]  = '{1'b0, 8'h00, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 8'h01, 32'h1234_56AB, 32'h0};
        vecs[10] = '{1'b0, 8'h01, 32'h0, 32'hAB};
        vecs[11] = '{1'b1, 8'h04, 32'hDEAD_BEEF, 32'h0};
        vecs[12] = '{1'b0, 8'h04, 32'h0, 32'hBEEF};
        vecs[13] = '{1'b1, 8'h05, 32'hFFFF_0000, 32'h0};
        vecs[14] = '{1'b0, 8'h05, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 8'h06, 32'hFF, 32'h0};
        vecs[16] = '{1'b0, 8'h06, 32'h0, 32'h1};
        vecs[17] = '{1'b1, 8'h20, 32'h55, 32'h0};
        vecs[18] = '{1'b0, 8'h20, 32'h0, 32'h0};
        vecs[19] = '{1'b1, 8'h07, 32'h1, 32'h0};
        vecs[20] = '{1'b0, 8'h00, 32'h0, 32'h0};
        vecs[21] = '{1'b1, 8'h00, 32'h2, 32'h0};
        vecs[22] = '{1'b0, 8'h00, 32'h0, 32'h2};
        vecs[23] = '{1'b0, 8'h06, 32'h0, 32'h1};
        vecs[24] = '{1'b1, 8'h00, 32'h0, 32'h0};
        vecs[25] = '{1'b0, 8'hFF, 32'h0, 32'h0};
        vecs[26] = '{1'b1, 8'h03, 32'h5A, 32'h0};
        vecs[27] = '{1'b0, 8'h03, 32'h0, 32'h5A};
        for (int i = 0; i < 28; i++) begin
            @(posedge clk); #1;
            cs = 1'b1; we = vecs[i].we; address = vecs[i].addr; write_data = vecs[i].wdata;
            @(posedge clk); #1;
            cs = 1'b0; we = 1'b0;
            check($sformatf("vec%0d_ready", i), 32'(rdy_p1), 32'h1);
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd_p1, vecs[i].exp_rd);
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle", i), {rd_p1[30:0], rdy_p1}, 32'h0);
        end

        // Blink: ON=2, OFF=0 (treated as 1) -> two periods on, one off.
        bus_write(8'h01, 32'h00);
        bus_write(8'h02, 32'hFF);
        bus_write(8'h03, 32'h40);
        bus_write(8'h04, 32'h2);
        bus_write(8'h05, 32'h0);
        bus_write(8'h00, 32'h3);
        mis_b = 0;
        foreach (hb[i, j]) hb[i][j] = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(posedge clk); #1;
            ph = (k - 1) % 256;
            p  = (k - 1) / 256;
            on = (p != 2);
            expb = {on && (ph < 64), on && (ph < 255), 1'b0};
            if (led_p1 !== expb) mis_b++;
            for (int c = 0; c < 3; c++) if (led_p1[c]) hb[p][c]++;
            if (k == 100 || k == 600 || k == 900) begin
                cs = 1'b1; we = 1'b0; address = 8'h06;
            end
            if (k == 101) begin
                check("status_on_p0", rd_p1, 32'h0000_6401);
                cs = 1'b0;
            end
            if (k == 601) begin
                check("status_off_p2", rd_p1, 32'h0000_5800);
                cs = 1'b0;
            end
            if (k == 901) begin
                check("status_on_p3", rd_p1, 32'h0000_8401);
                cs = 1'b0;
            end
        end
        check("blink_pattern_mismatches", 32'(mis_b), 32'h0);
        for (int q = 0; q < 4; q++) begin
            check($sformatf("blink_p%0d_ch0", q), 32'(hb[q][0]), 32'd0);
            check($sformatf("blink_p%0d_ch1", q), 32'(hb[q][1]), (q == 2) ? 32'd0 : 32'd255);
            check($sformatf("blink_p%0d_ch2", q), 32'(hb[q][2]), (q == 2) ? 32'd0 : 32'd64);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
